// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: state encoding,
// RV32I funct3 codes, the one-hot size strobe bundle and load extension.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
        logic sb;
        logic sh;
        logic sw;
    } lsu_strobe_t;

    // Extension is idempotent, so data that mmio already extended passes unchanged.
    function automatic logic [31:0] extendLoad(input logic [2:0] funct3, input logic [31:0] raw);
        case (funct3)
            F3_LB:   extendLoad = {{24{raw[7]}}, raw[7:0]};
            F3_LBU:  extendLoad = {24'h0, raw[7:0]};
            F3_LH:   extendLoad = {{16{raw[15]}}, raw[15:0]};
            F3_LHU:  extendLoad = {16'h0, raw[15:0]};
            default: extendLoad = raw;
        endcase
    endfunction

endpackage

// File: rtl/lsu_size_decode.sv
// Combinational decode of funct3 and access type into one-hot size strobes,
// a legality flag and the address bits that must be zero for alignment.
module lsu_size_decode
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    output lsu_strobe_t strobe_o,
    output logic        legal_o,
    output logic [1:0]  align_mask_o
);

    always_comb begin
        strobe_o     = '0;
        legal_o      = 1'b0;
        align_mask_o = 2'b00;
        if (is_load_i) begin
            legal_o = 1'b1;
            case (funct3_i)
                F3_LB:   strobe_o.lb = 1'b1;
                F3_LBU:  strobe_o.lbu = 1'b1;
                F3_LH:   begin strobe_o.lh = 1'b1;  align_mask_o = 2'b01; end
                F3_LHU:  begin strobe_o.lhu = 1'b1; align_mask_o = 2'b01; end
                F3_LW:   begin strobe_o.lw = 1'b1;  align_mask_o = 2'b11; end
                default: legal_o = 1'b0;
            endcase
        end else if (is_store_i) begin
            legal_o = 1'b1;
            case (funct3_i)
                F3_SB:   strobe_o.sb = 1'b1;
                F3_SH:   begin strobe_o.sh = 1'b1; align_mask_o = 2'b01; end
                F3_SW:   begin strobe_o.sw = 1'b1; align_mask_o = 2'b11; end
                default: legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one access to mmio, waits LOAD_LATENCY, returns the result.
// Define LSU_MISALIGN_TRAP_EN to report misaligned/unknown accesses through resp_err.
module lsu
    import lsu_pkg::*;
#(
    parameter int LOAD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_load_enable,
    output logic        bus_store_enable,
    output logic        bus_is_lb,
    output logic        bus_is_lbu,
    output logic        bus_is_lh,
    output logic        bus_is_lhu,
    output logic        bus_is_lw,
    output logic        bus_is_sb,
    output logic        bus_is_sh,
    output logic        bus_is_sw
);

    localparam logic [1:0] LAST_WAIT = 2'(LOAD_LATENCY - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        isLoad_q, err_q;
    lsu_strobe_t strobe_q;
    logic [1:0]  cnt_q;

    lsu_strobe_t decStrobe;
    logic        decLegal;
    logic [1:0]  decMask;
    logic [31:0] rawAddr, issueAddr;
    logic        accept, skipBus, errNow, busActive;

    lsu_size_decode u_decode (
        .funct3_i     (req_funct3),
        .is_load_i    (req_is_load),
        .is_store_i   (req_is_store),
        .strobe_o     (decStrobe),
        .legal_o      (decLegal),
        .align_mask_o (decMask)
    );

    assign rawAddr = req_base + req_offset;
    assign accept  = (state_q == IDLE) && req_valid && (req_is_load ^ req_is_store);

    // Accesses that skip the bus go straight from IDLE to DONE.
`ifdef LSU_MISALIGN_TRAP_EN
    assign skipBus   = !decLegal || ((rawAddr[1:0] & decMask) != 2'b00);
    assign errNow    = skipBus;
    assign issueAddr = rawAddr;
`else
    assign skipBus   = !decLegal;
    assign errNow    = 1'b0;
    assign issueAddr = {rawAddr[31:2], rawAddr[1:0] & ~decMask};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = skipBus ? DONE : ISSUE;
            ISSUE:   state_d = isLoad_q ? WAIT : DONE;
            WAIT:    if (cnt_q == LAST_WAIT) state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            isLoad_q <= 1'b0;
            err_q    <= 1'b0;
            strobe_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                addr_q   <= issueAddr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                isLoad_q <= req_is_load;
                strobe_q <= skipBus ? '0 : decStrobe;
                err_q    <= errNow;
                rdata_q  <= '0;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 2'd1 : 2'd0;
            if ((state_q == WAIT) && (cnt_q == LAST_WAIT)) begin
                rdata_q <= extendLoad(funct3_q, bus_rdata);
            end
        end
    end

    // All bus outputs derive from state_q so reset drops them asynchronously.
    always_comb begin
        busActive        = (state_q == ISSUE) || (state_q == WAIT);
        req_ready        = (state_q == IDLE);
        resp_valid       = (state_q == DONE);
        resp_rdata       = (state_q == DONE) ? rdata_q : 32'h0;
        resp_err         = (state_q == DONE) ? err_q : 1'b0;
        bus_address      = busActive ? addr_q : 32'h0;
        bus_wdata        = busActive ? wdata_q : 32'h0;
        bus_load_enable  = (state_q == ISSUE) && isLoad_q;
        bus_store_enable = (state_q == ISSUE) && !isLoad_q;
        bus_is_lb        = busActive && strobe_q.lb;
        bus_is_lbu       = busActive && strobe_q.lbu;
        bus_is_lh        = busActive && strobe_q.lh;
        bus_is_lhu       = busActive && strobe_q.lhu;
        bus_is_lw        = busActive && strobe_q.lw;
        bus_is_sb        = busActive && strobe_q.sb;
        bus_is_sh        = busActive && strobe_q.sh;
        bus_is_sw        = busActive && strobe_q.sw;
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: per-feature tasks plus a response scoreboard.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu;

    localparam int LL = 1;

    localparam logic [7:0] S_LB = 8'h80, S_LBU = 8'h40, S_LH = 8'h20, S_LHU = 8'h10;
    localparam logic [7:0] S_LW = 8'h08, S_SB = 8'h04, S_SH = 8'h02, S_SW = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_is_load = 1'b0, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_base = 32'h0, req_offset = 32'h0, req_wdata = 32'h0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, bus_address, bus_wdata, bus_rdata;
    logic        bus_load_enable, bus_store_enable;
    logic        bus_is_lb, bus_is_lbu, bus_is_lh, bus_is_lhu, bus_is_lw, bus_is_sb, bus_is_sh, bus_is_sw;
    logic [7:0]  strb;

    logic [31:0] memWord = 32'h0;
    int          sinceIssue = 0;
    int          cycleCnt = 0;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } resp_t;

    resp_t sbQ[$];
    resp_t obsQ[$];

    lsu #(.LOAD_LATENCY(LL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_load_enable(bus_load_enable), .bus_store_enable(bus_store_enable),
        .bus_is_lb(bus_is_lb), .bus_is_lbu(bus_is_lbu), .bus_is_lh(bus_is_lh), .bus_is_lhu(bus_is_lhu),
        .bus_is_lw(bus_is_lw), .bus_is_sb(bus_is_sb), .bus_is_sh(bus_is_sh), .bus_is_sw(bus_is_sw)
    );

    always #5 clk = ~clk;

    assign strb = {bus_is_lb, bus_is_lbu, bus_is_lh, bus_is_lhu, bus_is_lw, bus_is_sb, bus_is_sh, bus_is_sw};

    // Read data is only valid LL cycles after the ISSUE cycle; garbage otherwise.
    assign bus_rdata = (sinceIssue == LL) ? memWord : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sinceIssue <= 0;
        else if (bus_load_enable) sinceIssue <= 1;
        else if (sinceIssue != 0 && sinceIssue < 7) sinceIssue <= sinceIssue + 1;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every completed handshake for later comparison against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            obsQ.push_back('{resp_rdata, resp_err, cycleCnt});
        end
    end

    task automatic drive_req(input logic isLd, input logic isSt, input logic [2:0] f3,
                             input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                             input bit expectResp, input logic [31:0] expRdata, input logic expErr,
                             input int delay, output int acc);
        resp_t e;
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = isLd; req_is_store = isSt;
        req_funct3 = f3; req_base = base; req_offset = off; req_wdata = wd;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL req_ready_timeout: got %b expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        acc = cycleCnt;
        req_valid = 1'b0;
        if (expectResp) begin
            e.rdata = expRdata; e.err = expErr; e.cycle = acc + delay;
            sbQ.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL idle_timeout: req_ready got %b expected 1", req_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if ({resp_rdata, resp_err} !== 33'h0) begin fails++; $display("[TB] FAIL reset_resp: got %h/%b expected 0/0", resp_rdata, resp_err); end
        checks++; if ({bus_address, bus_wdata, strb, bus_load_enable, bus_store_enable} !== 74'h0) begin
            fails++; $display("[TB] FAIL reset_bus: addr %h wdata %h strb %h expected all 0", bus_address, bus_wdata, strb);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        int acc;
        memWord = 32'h8765_4321;
        drive_req(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1, 32'h8765_4321, 1'b0, 1 + LL, acc);
        @(negedge clk);
        checks++; if (strb !== S_LW) begin fails++; $display("[TB] FAIL lw_issue_strobe: got %h expected %h", strb, S_LW); end
        checks++; if ({bus_load_enable, bus_store_enable} !== 2'b10) begin fails++; $display("[TB] FAIL lw_issue_enable: got %b expected 10", {bus_load_enable, bus_store_enable}); end
        checks++; if (bus_address !== 32'h100) begin fails++; $display("[TB] FAIL lw_issue_addr: got %h expected 00000100", bus_address); end
        @(negedge clk);
        checks++; if ({strb, bus_load_enable, bus_address} !== {S_LW, 1'b0, 32'h100}) begin
            fails++; $display("[TB] FAIL lw_wait_hold: strb %h en %b addr %h expected %h 0 00000100", strb, bus_load_enable, bus_address, S_LW);
        end
        wait_idle();
    endtask

    task automatic test_load_byte();
        int acc;
        memWord = 32'hFFFF_FF87;
        drive_req(1, 0, 3'b000, 32'h100, 32'h3, 32'h0, 1, 32'hFFFF_FF87, 1'b0, 1 + LL, acc);
        @(negedge clk);
        checks++; if (strb !== S_LB || !$onehot(strb)) begin fails++; $display("[TB] FAIL lb_strobe: got %h expected %h", strb, S_LB); end
        checks++; if (bus_address !== 32'h103) begin fails++; $display("[TB] FAIL lb_addr: got %h expected 00000103", bus_address); end
        wait_idle();
        memWord = 32'h0000_0087;
        drive_req(1, 0, 3'b100, 32'h100, 32'h3, 32'h0, 1, 32'h0000_0087, 1'b0, 1 + LL, acc);
        @(negedge clk);
        checks++; if (strb !== S_LBU || !$onehot(strb)) begin fails++; $display("[TB] FAIL lbu_strobe: got %h expected %h", strb, S_LBU); end
        wait_idle();
    endtask

    task automatic test_store_half();
        int acc;
        drive_req(0, 1, 3'b001, 32'h32000, 32'h4, 32'h1234_ABCD, 1, 32'h0, 1'b0, 1, acc);
        @(negedge clk);
        checks++; if (strb !== S_SH) begin fails++; $display("[TB] FAIL sh_strobe: got %h expected %h", strb, S_SH); end
        checks++; if ({bus_store_enable, bus_load_enable} !== 2'b10) begin fails++; $display("[TB] FAIL sh_enable: got %b expected 10", {bus_store_enable, bus_load_enable}); end
        checks++; if (bus_wdata !== 32'h1234_ABCD) begin fails++; $display("[TB] FAIL sh_wdata: got %h expected 1234abcd", bus_wdata); end
        checks++; if (bus_address !== 32'h32004) begin fails++; $display("[TB] FAIL sh_addr: got %h expected 00032004", bus_address); end
        @(negedge clk);
        checks++; if ({bus_store_enable, strb, bus_address} !== 41'h0) begin
            fails++; $display("[TB] FAIL sh_done_bus: en %b strb %h addr %h expected 0 00 00000000", bus_store_enable, strb, bus_address);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        int acc;
        memWord = 32'h0BAD_F00D;
        drive_req(1, 0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1 + LL, acc);
        @(negedge clk);
        checks++; if (bus_address !== 32'h4) begin fails++; $display("[TB] FAIL wrap_addr: got %h expected 00000004", bus_address); end
        wait_idle();
    endtask

    task automatic test_misalign();
        int acc;
        int enSeen = 0;
        memWord = 32'h5555_AAAA;
`ifdef LSU_MISALIGN_TRAP_EN
        drive_req(1, 0, 3'b010, 32'h100, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_load_enable || bus_store_enable || strb != 8'h0) enSeen++;
        end
        checks++; if (enSeen != 0) begin fails++; $display("[TB] FAIL trap_no_bus: got %0d active cycles expected 0", enSeen); end
`else
        drive_req(1, 0, 3'b010, 32'h100, 32'h2, 32'h0, 1, 32'h5555_AAAA, 1'b0, 1 + LL, acc);
        @(negedge clk);
        checks++; if (bus_address !== 32'h100) begin fails++; $display("[TB] FAIL align_addr: got %h expected 00000100", bus_address); end
        checks++; if (strb !== S_LW) begin fails++; $display("[TB] FAIL align_strobe: got %h expected %h", strb, S_LW); end
`endif
        wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
        drive_req(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, acc);
`else
        drive_req(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0, acc);
`endif
        @(negedge clk);
        checks++; if ({bus_load_enable, strb} !== 9'h0) begin fails++; $display("[TB] FAIL illegal_f3_bus: en %b strb %h expected 0 00", bus_load_enable, strb); end
        wait_idle();
        // Load and store both set is ignored outright.
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({req_ready, bus_load_enable, bus_store_enable} !== 3'b100) begin
            fails++; $display("[TB] FAIL both_set_ignored: got %b expected 100", {req_ready, bus_load_enable, bus_store_enable});
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        drive_req(0, 1, 3'b010, 32'h200, 32'h0, 32'h1111_1111, 1, 32'h0, 1'b0, 1, a1);
        drive_req(0, 1, 3'b010, 32'h204, 32'h0, 32'h2222_2222, 1, 32'h0, 1'b0, 1, a2);
        drive_req(0, 1, 3'b010, 32'h208, 32'h0, 32'h3333_3333, 1, 32'h0, 1'b0, 1, a3);
        checks++; if (a2 - a1 != 3 || a3 - a2 != 3) begin fails++; $display("[TB] FAIL store_throughput: spacing %0d,%0d expected 3,3", a2 - a1, a3 - a2); end
        wait_idle();
    endtask

    task automatic test_stall_reset();
        int acc;
        int guard = 0;
        int bad = 0;
        memWord = 32'hCAFE_0123;
        resp_ready = 1'b0;
        drive_req(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 32'h0, 1'b0, 0, acc);
        while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_0123) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("[TB] FAIL stall_hold: got %0d bad cycles, rdata %h expected cafe0123", bad, resp_rdata); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 34'h0}) begin
            fails++; $display("[TB] FAIL stall_reset_resp: ready %b valid %b rdata %h expected 1 0 0", req_ready, resp_valid, resp_rdata);
        end
        checks++; if ({bus_address, strb, bus_load_enable} !== 41'h0) begin fails++; $display("[TB] FAIL stall_reset_bus: addr %h strb %h expected 0", bus_address, strb); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        // Store aborted while in ISSUE: enables must drop without waiting for a clock.
        drive_req(0, 1, 3'b000, 32'h400, 32'h0, 32'hAB, 0, 32'h0, 1'b0, 0, acc);
        checks++; if (bus_store_enable !== 1'b1) begin fails++; $display("[TB] FAIL abort_store_issue: got %b expected 1", bus_store_enable); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus_store_enable, bus_address, bus_wdata} !== 65'h0) begin
            fails++; $display("[TB] FAIL abort_store_drop: en %b addr %h wdata %h expected 0", bus_store_enable, bus_address, bus_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("[TB] FAIL aborted_no_resp: got %0d resp cycles expected 0", bad); end
    endtask

    task automatic test_scoreboard();
        resp_t e, o;
        checks++;
        if (obsQ.size() != sbQ.size()) begin
            fails++; $display("[TB] FAIL resp_count: got %0d expected %0d", obsQ.size(), sbQ.size());
        end
        while (sbQ.size() > 0 && obsQ.size() > 0) begin
            e = sbQ.pop_front();
            o = obsQ.pop_front();
            checks++; if (o.rdata !== e.rdata) begin fails++; $display("[TB] FAIL resp_rdata: got %h expected %h", o.rdata, e.rdata); end
            checks++; if (o.err !== e.err) begin fails++; $display("[TB] FAIL resp_err: got %b expected %b", o.err, e.err); end
            checks++; if (o.cycle != e.cycle) begin fails++; $display("[TB] FAIL resp_cycle: got %0d expected %0d", o.cycle, e.cycle); end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_wrap();
        test_misalign();
        test_back_to_back();
        test_stall_reset();
        test_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
